// File: rtl/atm_session_arbiter.sv
// Round-robin session arbiter sharing one ATM transaction engine among card terminals.
// Handles session start pulse, idle-timeout abort and drain-until-engine-idle handover.
module atm_session_arbiter #(
    parameter int unsigned N_TERM         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned ID_W           = $clog2(N_TERM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_TERM-1:0] term_req_i,
    input  logic [N_TERM-1:0] term_release_i,
    input  logic [N_TERM-1:0] term_activity_i,
    input  logic              eng_busy_i,
    output logic [N_TERM-1:0] grant_o,
    output logic [ID_W-1:0]   grant_id_o,
    output logic              grant_valid_o,
    output logic              eng_start_o,
    output logic              eng_abort_o,
    output logic              timeout_evt_o,
    output logic [15:0]       session_count_o,
    output logic [7:0]        timeout_count_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_ABORT  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [N_TERM-1:0] grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              eng_start_q, eng_start_d;
    logic              eng_abort_q, eng_abort_d;
    logic              timeout_evt_q, timeout_evt_d;
    logic [15:0]       session_count_q, session_count_d;
    logic [7:0]        timeout_count_q, timeout_count_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              owner_req;
    logic              owner_release;
    logic              owner_activity;

    // Round-robin pick: first requester scanning upward from last_id+1.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] idx_w;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        idx_w      = '0;
        for (int unsigned i = 0; i < N_TERM; i++) begin
            idx   = (32'(last_id_q) + 32'd1 + i) % N_TERM;
            idx_w = ID_W'(idx);
            if (!pick_found && term_req_i[idx_w]) begin
                pick_found = 1'b1;
                pick_id    = idx_w;
            end
        end
    end

    assign owner_req      = |(term_req_i & grant_q);
    assign owner_release  = |(term_release_i & grant_q);
    assign owner_activity = |(term_activity_i & grant_q);

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        grant_id_d      = grant_id_q;
        grant_valid_d   = grant_valid_q;
        last_id_d       = last_id_q;
        idle_cnt_d      = idle_cnt_q;
        eng_start_d     = 1'b0;
        eng_abort_d     = 1'b0;
        timeout_evt_d   = 1'b0;
        session_count_d = session_count_q;
        timeout_count_d = timeout_count_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d       = N_TERM'(1) << pick_id;
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    eng_start_d   = 1'b1;
                    state_d       = S_START;
                end
            end
            S_START: begin
                idle_cnt_d = '0;
                state_d    = S_ACTIVE;
            end
            S_ACTIVE: begin
                // Release (or owner dropping its request) beats activity and timeout.
                if (owner_release || !owner_req) begin
                    state_d = S_DRAIN;
                end else if (owner_activity) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CNT_LIMIT) begin
                    state_d       = S_ABORT;
                    eng_abort_d   = 1'b1;
                    timeout_evt_d = 1'b1;
                    if (timeout_count_q != 8'hFF) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            S_ABORT: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!eng_busy_i) begin
                    grant_d         = '0;
                    grant_id_d      = '0;
                    grant_valid_d   = 1'b0;
                    last_id_d       = grant_id_q;
                    session_count_d = session_count_q + 16'd1;
                    state_d         = S_IDLE;
                end
            end
            default: begin
                state_d       = S_IDLE;
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            grant_q         <= '0;
            grant_id_q      <= '0;
            grant_valid_q   <= 1'b0;
            last_id_q       <= ID_W'(N_TERM - 1);
            idle_cnt_q      <= '0;
            eng_start_q     <= 1'b0;
            eng_abort_q     <= 1'b0;
            timeout_evt_q   <= 1'b0;
            session_count_q <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            grant_id_q      <= grant_id_d;
            grant_valid_q   <= grant_valid_d;
            last_id_q       <= last_id_d;
            idle_cnt_q      <= idle_cnt_d;
            eng_start_q     <= eng_start_d;
            eng_abort_q     <= eng_abort_d;
            timeout_evt_q   <= timeout_evt_d;
            session_count_q <= session_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign grant_o         = grant_q;
    assign grant_id_o      = grant_id_q;
    assign grant_valid_o   = grant_valid_q;
    assign eng_start_o     = eng_start_q;
    assign eng_abort_o     = eng_abort_q;
    assign timeout_evt_o   = timeout_evt_q;
    assign session_count_o = session_count_q;
    assign timeout_count_o = timeout_count_q;

endmodule
